// File: rtl/vga_vram.sv
// vga_vram: single-port 32-bit video RAM behind two pipelined Wishbone slave ports.
// Video wins contention; a saturating starvation counter forces a CPU grant after CPU_MAX_WAIT losses.
module vga_vram #(
  parameter int AWIDTH       = 12,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_vid_cyc,
  input  logic        i_vid_stb,
  input  logic        i_vid_we,
  input  logic [3:0]  i_vid_sel,
  input  logic [31:0] i_vid_adr,
  input  logic [31:0] i_vid_dat,
  output logic [31:0] o_vid_dat,
  output logic        o_vid_ack,
  output logic        o_vid_stall,
  input  logic        i_cpu_cyc,
  input  logic        i_cpu_stb,
  input  logic        i_cpu_we,
  input  logic [3:0]  i_cpu_sel,
  input  logic [31:0] i_cpu_adr,
  input  logic [31:0] i_cpu_dat,
  output logic [31:0] o_cpu_dat,
  output logic        o_cpu_ack,
  output logic        o_cpu_stall
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int CW    = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(CPU_MAX_WAIT);

  logic              w_vid_req;
  logic              w_cpu_req;
  logic              w_starved;
  logic              w_vid_gnt;
  logic              w_cpu_gnt;
  logic              w_we;
  logic [3:0]        w_sel;
  logic [31:0]       w_wdat;
  logic [AWIDTH-1:0] w_idx;
  logic              w_wr_en;
  logic [31:0]       w_ram_q;
  logic              w_unused;

  logic [CW-1:0]     r_starve;
  logic              r_vid_ack;
  logic              r_cpu_ack;
  logic              r_vid_rd;
  logic              r_cpu_rd;
  logic [31:0]       r_vid_hold;
  logic [31:0]       r_cpu_hold;

  // Arbitration depends only on cyc/stb and the counter, never on we/adr.
  assign w_vid_req   = i_vid_cyc & i_vid_stb;
  assign w_cpu_req   = i_cpu_cyc & i_cpu_stb;
  assign w_starved   = (r_starve == MAX_CNT);
  assign w_cpu_gnt   = w_cpu_req & (~w_vid_req | w_starved);
  assign w_vid_gnt   = w_vid_req & ~w_cpu_gnt;
  assign o_vid_stall = w_vid_req & ~w_vid_gnt;
  assign o_cpu_stall = w_cpu_req & ~w_cpu_gnt;

  always_comb begin
    w_we   = 1'b0;
    w_sel  = 4'h0;
    w_wdat = 32'h0;
    w_idx  = '0;
    if (w_cpu_gnt) begin
      w_we   = i_cpu_we;
      w_sel  = i_cpu_sel;
      w_wdat = i_cpu_dat;
      w_idx  = i_cpu_adr[AWIDTH+1:2];
    end else if (w_vid_gnt) begin
      w_we   = i_vid_we;
      w_sel  = i_vid_sel;
      w_wdat = i_vid_dat;
      w_idx  = i_vid_adr[AWIDTH+1:2];
    end
  end

  // Requests presented while reset is held are dropped, including their writes.
  assign w_wr_en = (w_vid_gnt | w_cpu_gnt) & w_we & ~rst_i;

  // One RAM per byte lane so the byte enables map onto plain write enables.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH];
      logic [7:0] r_lane_q;

      always_ff @(posedge clk_i) begin
        if (w_wr_en && w_sel[gi]) begin
          r_lane[w_idx] <= w_wdat[8*gi +: 8];
        end
        r_lane_q <= r_lane[w_idx];
      end

      assign w_ram_q[8*gi +: 8] = r_lane_q;
    end
  endgenerate

  // The RAM output register is shared; each port keeps a hold copy so its
  // dat_o survives later writes and the other port's reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve   <= '0;
      r_vid_ack  <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_vid_rd   <= 1'b0;
      r_cpu_rd   <= 1'b0;
      r_vid_hold <= 32'h0;
      r_cpu_hold <= 32'h0;
    end else begin
      r_vid_ack <= w_vid_gnt;
      r_cpu_ack <= w_cpu_gnt;
      r_vid_rd  <= w_vid_gnt & ~i_vid_we;
      r_cpu_rd  <= w_cpu_gnt & ~i_cpu_we;
      if (r_vid_rd) begin
        r_vid_hold <= w_ram_q;
      end
      if (r_cpu_rd) begin
        r_cpu_hold <= w_ram_q;
      end
      if (w_cpu_req && w_vid_gnt) begin
        if (!w_starved) begin
          r_starve <= r_starve + 1'b1;
        end
      end else begin
        r_starve <= '0;
      end
    end
  end

  assign o_vid_dat = r_vid_rd ? w_ram_q : r_vid_hold;
  assign o_cpu_dat = r_cpu_rd ? w_ram_q : r_cpu_hold;
  assign o_vid_ack = r_vid_ack & i_vid_cyc;
  assign o_cpu_ack = r_cpu_ack & i_cpu_cyc;

  assign w_unused = ^{i_vid_adr[31:AWIDTH+2], i_vid_adr[1:0],
                      i_cpu_adr[31:AWIDTH+2], i_cpu_adr[1:0]};

endmodule

// File: tb/tb_vga_vram.sv
// Bench for vga_vram: directed vector table, hand-written corner sequences and
// randomized traffic checked every cycle against a transaction-level model.
module tb_vga_vram;
  localparam int AW    = 12;
  localparam int MAXW  = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_vid_cyc, i_vid_stb, i_vid_we;
  logic [3:0]  i_vid_sel;
  logic [31:0] i_vid_adr, i_vid_dat, o_vid_dat;
  logic        o_vid_ack, o_vid_stall;
  logic        i_cpu_cyc, i_cpu_stb, i_cpu_we;
  logic [3:0]  i_cpu_sel;
  logic [31:0] i_cpu_adr, i_cpu_dat, o_cpu_dat;
  logic        o_cpu_ack, o_cpu_stall;

  vga_vram #(.AWIDTH(AW), .CPU_MAX_WAIT(MAXW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_vid_cyc(i_vid_cyc), .i_vid_stb(i_vid_stb), .i_vid_we(i_vid_we),
    .i_vid_sel(i_vid_sel), .i_vid_adr(i_vid_adr), .i_vid_dat(i_vid_dat),
    .o_vid_dat(o_vid_dat), .o_vid_ack(o_vid_ack), .o_vid_stall(o_vid_stall),
    .i_cpu_cyc(i_cpu_cyc), .i_cpu_stb(i_cpu_stb), .i_cpu_we(i_cpu_we),
    .i_cpu_sel(i_cpu_sel), .i_cpu_adr(i_cpu_adr), .i_cpu_dat(i_cpu_dat),
    .o_cpu_dat(o_cpu_dat), .o_cpu_ack(o_cpu_ack), .o_cpu_stall(o_cpu_stall)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (port 0 = video, 1 = cpu) ----------------
  logic [31:0] m_mem   [DEPTH];
  logic [3:0]  m_known [DEPTH];
  int          m_waited;            // cycles the CPU has been held off so far
  logic        m_ack_due   [2];
  logic [31:0] m_dat       [2];
  logic        m_dat_known [2];
  bit          model_on = 1'b0;

  task automatic model_reset();
    m_waited = 0;
    for (int p = 0; p < 2; p++) begin
      m_ack_due[p]   = 1'b0;
      m_dat[p]       = 32'h0;
      m_dat_known[p] = 1'b1;
    end
  endtask

  // -1 = nobody, 0 = video, 1 = cpu
  function automatic int winner(input logic vv, input logic cv);
    if (vv && cv) return (m_waited >= MAXW) ? 1 : 0;
    if (vv) return 0;
    if (cv) return 1;
    return -1;
  endfunction

  task automatic model_step();
    logic vv, cv, we;
    logic [3:0] sel;
    logic [31:0] adr, wd;
    int w, idx;
    if (rst_i) begin
      model_reset();
      return;
    end
    vv = i_vid_cyc & i_vid_stb;
    cv = i_cpu_cyc & i_cpu_stb;
    w  = winner(vv, cv);
    m_ack_due[0] = (w == 0);
    m_ack_due[1] = (w == 1);
    if (w >= 0) begin
      if (w == 0) begin we = i_vid_we; sel = i_vid_sel; adr = i_vid_adr; wd = i_vid_dat; end
      else        begin we = i_cpu_we; sel = i_cpu_sel; adr = i_cpu_adr; wd = i_cpu_dat; end
      idx = int'((adr >> 2) % DEPTH);
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) begin
            m_mem[idx][8*b +: 8] = wd[8*b +: 8];
            m_known[idx][b] = 1'b1;
          end
        end
      end else begin
        m_dat[w]       = m_mem[idx];
        m_dat_known[w] = (m_known[idx] == 4'hF);
      end
    end
    if (cv && w == 0) m_waited = (m_waited < MAXW) ? m_waited + 1 : MAXW;
    else              m_waited = 0;
  endtask

  task automatic model_check();
    logic vv, cv;
    int w;
    vv = i_vid_cyc & i_vid_stb;
    cv = i_cpu_cyc & i_cpu_stb;
    w  = winner(vv, cv);
    chk_bit("m_vid_stall", o_vid_stall, vv && (w != 0));
    chk_bit("m_cpu_stall", o_cpu_stall, cv && (w != 1));
    chk_bit("m_vid_ack", o_vid_ack, m_ack_due[0] && i_vid_cyc);
    chk_bit("m_cpu_ack", o_cpu_ack, m_ack_due[1] && i_cpu_cyc);
    if (m_dat_known[0]) chk_word("m_vid_dat", o_vid_dat, m_dat[0]);
    if (m_dat_known[1]) chk_word("m_cpu_dat", o_cpu_dat, m_dat[1]);
  endtask

  always @(posedge clk_i) if (model_on) model_step();
  always @(negedge clk_i) if (model_on) model_check();
  always @(posedge rst_i) model_reset();

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic port, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    if (port) begin
      i_cpu_cyc = cyc; i_cpu_stb = stb; i_cpu_we = we;
      i_cpu_sel = sel; i_cpu_adr = adr; i_cpu_dat = dat;
    end else begin
      i_vid_cyc = cyc; i_vid_stb = stb; i_vid_we = we;
      i_vid_sel = sel; i_vid_adr = adr; i_vid_dat = dat;
    end
  endtask

  task automatic idle_all();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  typedef struct packed {
    logic        port;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  // One single-request transaction: wait (bounded) for acceptance, then check the ack.
  task automatic xfer(input vec_t v, output logic [31:0] rdat);
    int guard;
    bit got;
    @(posedge clk_i); #1;
    drive(v.port, 1'b1, 1'b1, v.we, v.sel, v.adr, v.wdat);
    guard = 0;
    got   = 1'b0;
    while (!got && guard < 20) begin
      @(negedge clk_i);
      if (!(v.port ? o_cpu_stall : o_vid_stall)) got = 1'b1;
      else guard++;
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL xfer_accept actual=stalled required=accepted within 20 cycles t=%0t", $time);
    end
    @(posedge clk_i); #1;
    drive(v.port, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    chk_bit("xfer_ack", v.port ? o_cpu_ack : o_vid_ack, 1'b1);
    rdat = v.port ? o_cpu_dat : o_vid_dat;
    @(posedge clk_i); #1;
    drive(v.port, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  vec_t tbl [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rdat;
    vec_t v;

    idle_all();
    rst_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 4'h0;
    model_reset();

    // port, we, sel, adr, wdat, expected read data
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 4'h1, 32'h0000_0010, 32'h0000_00AA, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEAA};
    tbl[3]  = '{1'b1, 1'b0, 4'hF, 32'h0000_4010, 32'h0,         32'hDEAD_BEAA};
    tbl[4]  = '{1'b0, 1'b0, 4'hF, 32'hFFFF_C013, 32'h0,         32'hDEAD_BEAA};
    tbl[5]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 4'h6, 32'h0000_0020, 32'h1122_3344, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'hFF22_33FF};
    tbl[8]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0024, 32'h0,         32'h0};
    tbl[9]  = '{1'b1, 1'b1, 4'h0, 32'h0000_0024, 32'h5555_5555, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 4'hF, 32'h0000_0024, 32'h0,         32'h0};
    tbl[11] = '{1'b0, 1'b1, 4'hF, 32'h0000_0030, 32'hCAFE_F00D, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 4'hF, 32'h0000_0030, 32'h0,         32'hCAFE_F00D};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_bit("rst_vid_ack", o_vid_ack, 1'b0);
    chk_bit("rst_cpu_ack", o_cpu_ack, 1'b0);
    chk_word("rst_vid_dat", o_vid_dat, 32'h0);
    chk_word("rst_cpu_dat", o_cpu_dat, 32'h0);
    #2 rst_i = 1'b0;
    model_on = 1'b1;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      xfer(tbl[i], rdat);
      if (!tbl[i].we) chk_word($sformatf("tbl%0d_dat", i), rdat, tbl[i].exp);
      $display("xfer %0d port=%s %s adr=%h sel=%h wdat=%h rdat=%h", i,
               tbl[i].port ? "cpu" : "vid", tbl[i].we ? "W" : "R",
               tbl[i].adr, tbl[i].sel, tbl[i].wdat, rdat);
    end

    // Preload words 0..7 with their index, then a pipelined video burst
    for (int i = 0; i < 8; i++) begin
      v = '{1'b1, 1'b1, 4'hF, 32'(i * 4), 32'(i), 32'h0};
      xfer(v, rdat);
    end
    @(posedge clk_i); #1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'(i * 4), 32'h0);
      else       drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk_i);
      if (i < 8) chk_bit($sformatf("burst_stall%0d", i), o_vid_stall, 1'b0);
      if (i >= 1 && i <= 8) begin
        chk_bit($sformatf("burst_ack%0d", i - 1), o_vid_ack, 1'b1);
        chk_word($sformatf("burst_dat%0d", i - 1), o_vid_dat, 32'(i - 1));
      end
      if (i == 9) chk_bit("burst_ack_end", o_vid_ack, 1'b0);
      $display("burst cycle %0d ack=%b dat=%h", i, o_vid_ack, o_vid_dat);
      @(posedge clk_i); #1;
    end
    idle_all();

    // Contention: video streams reads, CPU keeps requesting word 5 through two rounds
    @(posedge clk_i); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
    for (int r = 0; r < 2; r++) begin
      int stalls;
      bit granted;
      stalls  = (r == 0) ? 0 : 1;
      granted = 1'b0;
      while (!granted && stalls < 20) begin
        @(negedge clk_i);
        if (o_cpu_stall) begin
          stalls++;
          @(posedge clk_i); #1;
        end else begin
          granted = 1'b1;
          chk_bit("cont_vid_stalled", o_vid_stall, 1'b1);
        end
      end
      chk_word($sformatf("cont_cpu_wait_r%0d", r), 32'(stalls), 32'(MAXW));
      @(posedge clk_i); #1;
      if (r == 1) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk_i);
      chk_bit("cont_cpu_ack", o_cpu_ack, 1'b1);
      chk_word("cont_cpu_dat", o_cpu_dat, 32'h5);
      chk_bit("cont_vid_resume", o_vid_stall, 1'b0);
      if (r == 0) begin
        chk_bit("cont_cpu_restall", o_cpu_stall, 1'b1);
        @(posedge clk_i); #1;
      end
      $display("contention round %0d cpu_wait=%0d", r, stalls);
    end
    @(posedge clk_i); #1;
    idle_all();

    // Abort: CPU read accepted, cyc dropped the next cycle
    @(posedge clk_i); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk_i);
    chk_bit("abort_accept", o_cpu_stall, 1'b0);
    @(posedge clk_i); #1;
    idle_all();
    @(negedge clk_i);
    chk_bit("abort_no_ack", o_cpu_ack, 1'b0);
    v = '{1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 32'h4};
    xfer(v, rdat);
    chk_word("abort_next_dat", rdat, 32'h4);
    $display("abort sequence next read dat=%h", rdat);

    // Same-word read-after-write across ports
    @(posedge clk_i); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h40, 32'h1234_5678);
    @(posedge clk_i); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    @(posedge clk_i); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    chk_bit("raw_vid_ack", o_vid_ack, 1'b1);
    chk_word("raw_vid_dat", o_vid_dat, 32'h1234_5678);
    $display("raw cpu write -> vid read dat=%h", o_vid_dat);
    @(posedge clk_i); #1;
    idle_all();

    // Reset mid-transfer: video read of word 1 accepted, then reset asserted
    @(posedge clk_i); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    chk_bit("rstmid_vid_ack", o_vid_ack, 1'b0);
    chk_bit("rstmid_cpu_ack", o_cpu_ack, 1'b0);
    chk_word("rstmid_vid_dat", o_vid_dat, 32'h0);
    chk_word("rstmid_cpu_dat", o_cpu_dat, 32'h0);
    idle_all();
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b0;
    @(posedge clk_i); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk_i);
    chk_bit("postrst_no_early_ack", o_cpu_ack, 1'b0);
    @(posedge clk_i); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    chk_bit("postrst_ack", o_cpu_ack, 1'b1);
    chk_word("postrst_dat", o_cpu_dat, 32'h4);
    $display("post-reset read dat=%h", o_cpu_dat);
    @(posedge clk_i); #1;
    idle_all();

    // Randomized traffic on both ports, checked by the model every cycle
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk_i); #1;
      drive(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
            4'($urandom_range(0, 15)),
            ($urandom() & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2), $urandom());
      drive(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) == 0,
            4'($urandom_range(0, 15)),
            ($urandom() & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2), $urandom());
    end
    @(posedge clk_i); #1;
    idle_all();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
